// File: rtl/bru_pkg.sv
// Shared types and constants for the branch resolution unit.
//   br_funct3_e : legal RV32 branch funct3 encodings
//   bht_ctr_t   : 2-bit saturating branch history counter
//   ctr_next()  : saturating counter training step
package bru_pkg;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } br_funct3_e;

  typedef logic [1:0] bht_ctr_t;

  localparam bht_ctr_t CTR_SNT   = 2'b00;
  localparam bht_ctr_t CTR_WNT   = 2'b01;
  localparam bht_ctr_t CTR_WT    = 2'b10;
  localparam bht_ctr_t CTR_ST    = 2'b11;
  localparam bht_ctr_t BHT_RESET = CTR_WNT;

  // Move one step toward the observed outcome, saturating at either end.
  function automatic bht_ctr_t ctr_next(input bht_ctr_t c, input logic taken);
    if (taken) begin
      return (c == CTR_ST) ? CTR_ST : bht_ctr_t'(c + 2'd1);
    end
    return (c == CTR_SNT) ? CTR_SNT : bht_ctr_t'(c - 2'd1);
  endfunction

endpackage

// File: rtl/bru_bht.sv
// Branch history table: array of 2-bit saturating counters.
//   clk, rst          : clock, async active-high reset (all counters -> BHT_RESET)
//   rd_idx / rd_taken : combinational lookup, returns counter MSB
//   wr_en, wr_idx,
//   wr_taken          : synchronous training of one counter per cycle
module bru_bht
  import bru_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  localparam int unsigned IDX_W  = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  bht_ctr_t ctr_q [ENTRIES];

  // Counter storage; a same-index read this cycle sees the pre-update value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        ctr_q[i] <= BHT_RESET;
      end
    end else if (wr_en) begin
      ctr_q[wr_idx] <= ctr_next(ctr_q[wr_idx], wr_taken);
    end
  end

  assign rd_taken = ctr_q[rd_idx][1];

endmodule

// File: rtl/branch_resolve_unit.sv
// Registered branch resolution stage following the ALU comparator.
// Decodes funct3 against comparator flags, computes taken/redirect PC,
// flags mispredictions and trains a small BHT read by fetch.
//   in_*  / in_ready   : branch op handshake (accept = in_valid & in_ready & !flush)
//   cmp_*              : signed and unsigned comparator flags
//   flush              : drops output and any op presented this cycle
//   fetch_pc / fetch_pred_taken : combinational BHT lookup
//   out_* / out_ready  : registered result handshake, 1-cycle latency
// Optional build macro BRU_STATS_EN adds saturating stat_branches and
// stat_mispredicts counters.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned BHT_ENTRIES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_funct3,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic [DATA_WIDTH-1:0] in_imm,
  input  logic                  in_pred_taken,
  input  logic                  cmp_greater,
  input  logic                  cmp_equal,
  input  logic                  cmp_less,
  input  logic                  cmp_greater_u,
  input  logic                  cmp_less_u,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] fetch_pc,
  output logic                  fetch_pred_taken,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_taken,
  output logic                  out_mispredict,
  output logic [DATA_WIDTH-1:0] out_redirect_pc,
  output logic                  out_illegal
`ifdef BRU_STATS_EN
  ,
  output logic [31:0]           stat_branches,
  output logic [31:0]           stat_mispredicts
`endif
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

  logic                  accept;
  logic                  taken_c;
  logic                  illegal_c;
  logic                  mispredict_c;
  logic [DATA_WIDTH-1:0] redirect_c;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // Branch condition decode; 010/011 are not branches.
  always_comb begin
    taken_c   = 1'b0;
    illegal_c = 1'b0;
    case (in_funct3)
      F3_BEQ:  taken_c = cmp_equal;
      F3_BNE:  taken_c = !cmp_equal;
      F3_BLT:  taken_c = cmp_less;
      F3_BGE:  taken_c = cmp_greater || cmp_equal;
      F3_BLTU: taken_c = cmp_less_u;
      F3_BGEU: taken_c = cmp_greater_u || cmp_equal;
      default: illegal_c = 1'b1;
    endcase
  end

  assign mispredict_c = taken_c != in_pred_taken;
  assign redirect_c   = taken_c ? DATA_WIDTH'(in_pc + in_imm)
                                : DATA_WIDTH'(in_pc + DATA_WIDTH'(4));

  // Result register; flush wins over accept, backpressure holds contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid       <= 1'b0;
      out_taken       <= 1'b0;
      out_mispredict  <= 1'b0;
      out_redirect_pc <= '0;
      out_illegal     <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid       <= 1'b1;
      out_taken       <= taken_c;
      out_mispredict  <= mispredict_c;
      out_redirect_pc <= redirect_c;
      out_illegal     <= illegal_c;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Only the word-index bits of fetch_pc select a counter.
  logic unused_fetch_bits;
  assign unused_fetch_bits = ^{fetch_pc[DATA_WIDTH-1:IDX_W+2], fetch_pc[1:0]};

  bru_bht #(
    .ENTRIES (BHT_ENTRIES)
  ) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (fetch_pc[IDX_W+1:2]),
    .rd_taken (fetch_pred_taken),
    .wr_en    (accept && !illegal_c),
    .wr_idx   (in_pc[IDX_W+1:2]),
    .wr_taken (taken_c)
  );

`ifdef BRU_STATS_EN
  // Saturating event counters for accepted legal branches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (accept && !illegal_c) begin
      if (stat_branches != 32'hFFFF_FFFF) begin
        stat_branches <= stat_branches + 32'd1;
      end
      if (mispredict_c && (stat_mispredicts != 32'hFFFF_FFFF)) begin
        stat_mispredicts <= stat_mispredicts + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: the driver derives comparator
// flags from random operands, predicts results from the branch semantics
// and pushes them; a negedge monitor pops and compares DUT outputs.
module tb_branch_resolve_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_funct3;
  logic [31:0] in_pc;
  logic [31:0] in_imm;
  logic        in_pred_taken;
  logic        cmp_greater, cmp_equal, cmp_less, cmp_greater_u, cmp_less_u;
  logic        flush;
  logic [31:0] fetch_pc;
  logic        fetch_pred_taken;
  logic        out_valid;
  logic        out_ready;
  logic        out_taken;
  logic        out_mispredict;
  logic [31:0] out_redirect_pc;
  logic        out_illegal;

  branch_resolve_unit #(.DATA_WIDTH(32), .BHT_ENTRIES(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
    .in_pc(in_pc), .in_imm(in_imm), .in_pred_taken(in_pred_taken),
    .cmp_greater(cmp_greater), .cmp_equal(cmp_equal), .cmp_less(cmp_less),
    .cmp_greater_u(cmp_greater_u), .cmp_less_u(cmp_less_u),
    .flush(flush), .fetch_pc(fetch_pc), .fetch_pred_taken(fetch_pred_taken),
    .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
    .out_mispredict(out_mispredict), .out_redirect_pc(out_redirect_pc),
    .out_illegal(out_illegal)
  );

  typedef struct {
    logic        taken;
    logic        mis;
    logic        ill;
    logic [31:0] pc;
  } exp_t;

  exp_t q[$];
  int   bht[16];
  logic exp_ovalid;
  int   vectors = 0;
  int   miscompares = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) & 32'd15);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) bht[i] = 1;
    q.delete();
    exp_ovalid = 1'b0;
  endtask

  // One clock of stimulus; expectations are formed from operand values.
  task automatic cyc(input logic v, input logic [2:0] f3, input logic [31:0] pc,
                     input logic [31:0] imm, input logic [31:0] a, input logic [31:0] b,
                     input logic pred, input logic fl, input logic rdy,
                     input logic [31:0] fpc);
    exp_t e;
    logic exp_ready;
    logic acc;
    int   ix;
    @(posedge clk);
    #1;
    in_valid      = v;
    in_funct3     = f3;
    in_pc         = pc;
    in_imm        = imm;
    in_pred_taken = pred;
    cmp_greater   = $signed(a) > $signed(b);
    cmp_equal     = a == b;
    cmp_less      = $signed(a) < $signed(b);
    cmp_greater_u = a > b;
    cmp_less_u    = a < b;
    flush         = fl;
    out_ready     = rdy;
    fetch_pc      = fpc;
    @(negedge clk);
    #1;
    exp_ready = !exp_ovalid || rdy;
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    check("fetch_pred", 32'(fetch_pred_taken), 32'(bht[idx_of(fpc)] >= 2));
    acc = v && exp_ready && !fl;
    if (acc) begin
      e.ill = (f3 == 3'b010) || (f3 == 3'b011);
      case (f3)
        3'b000:  e.taken = (a == b);
        3'b001:  e.taken = (a != b);
        3'b100:  e.taken = ($signed(a) <  $signed(b));
        3'b101:  e.taken = ($signed(a) >= $signed(b));
        3'b110:  e.taken = (a <  b);
        3'b111:  e.taken = (a >= b);
        default: e.taken = 1'b0;
      endcase
      e.mis = e.taken != pred;
      e.pc  = e.taken ? pc + imm : pc + 32'd4;
      q.push_back(e);
      if (!e.ill) begin
        ix = idx_of(pc);
        if (e.taken) bht[ix] = (bht[ix] == 3) ? 3 : bht[ix] + 1;
        else         bht[ix] = (bht[ix] == 0) ? 0 : bht[ix] - 1;
      end
    end
    if (fl)        exp_ovalid = 1'b0;
    else if (acc)  exp_ovalid = 1'b1;
    else if (rdy)  exp_ovalid = 1'b0;
  endtask

  task automatic idle(input logic rdy, input logic [31:0] fpc);
    cyc(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h1, 1'b0, 1'b0, rdy, fpc);
  endtask

  task automatic check_reset_outputs();
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_taken", 32'(out_taken), 32'h0);
    check("rst_out_mispredict", 32'(out_mispredict), 32'h0);
    check("rst_out_illegal", 32'(out_illegal), 32'h0);
    check("rst_out_redirect_pc", out_redirect_pc, 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
  endtask

  // Asynchronous reset asserted mid-cycle, released between edges.
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst      = 1'b1;
    in_valid = 1'b0;
    model_reset();
    #1;
    check_reset_outputs();
    @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  // Monitor: output must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst) begin
      check("out_valid", 32'(out_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        if (out_valid) begin
          check("out_taken", 32'(out_taken), 32'(q[0].taken));
          check("out_mispredict", 32'(out_mispredict), 32'(q[0].mis));
          check("out_illegal", 32'(out_illegal), 32'(q[0].ill));
          check("out_redirect_pc", out_redirect_pc, q[0].pc);
        end
        if (out_ready || flush) void'(q.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] a, b, pc;
    rst = 1'b1;
    in_valid = 1'b0; in_funct3 = 3'b000; in_pc = '0; in_imm = '0;
    in_pred_taken = 1'b0; cmp_greater = 1'b0; cmp_equal = 1'b0; cmp_less = 1'b0;
    cmp_greater_u = 1'b0; cmp_less_u = 1'b0; flush = 1'b0; fetch_pc = '0;
    out_ready = 1'b0;
    model_reset();
    #12;
    check_reset_outputs();
    check("rst_fetch_pred", 32'(fetch_pred_taken), 32'h0);
    @(negedge clk);
    #2;
    rst = 1'b0;

    // BEQ taken, predicted not taken; BHT[0] trains 01 -> 10
    cyc(1'b1, 3'b000, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0, 1'b0, 1'b1, 32'h100);
    idle(1'b1, 32'h100);
    // BLTU taken with PC wrap-around
    cyc(1'b1, 3'b110, 32'hFFFF_FFFC, 32'h8, 32'd1, 32'd2, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    // Illegal funct3: not taken, pc+4, no training
    cyc(1'b1, 3'b010, 32'h200, 32'h40, 32'd3, 32'd3, 1'b1, 1'b0, 1'b1, 32'h200);
    idle(1'b1, 32'h200);
    // Backpressure: hold three cycles, then accept while draining
    cyc(1'b1, 3'b001, 32'h300, 32'h10, 32'd1, 32'd2, 1'b1, 1'b0, 1'b0, 32'h300);
    repeat (3) cyc(1'b1, 3'b100, 32'h304, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0, 32'h300);
    cyc(1'b1, 3'b100, 32'h304, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1, 32'h304);
    idle(1'b1, 32'h304);
    // Four taken at 0x40: saturate, lookups return pre-update bit
    repeat (4) cyc(1'b1, 3'b101, 32'h40, 32'h100, 32'd9, 32'd2, 1'b1, 1'b0, 1'b1, 32'h40);
    idle(1'b1, 32'h40);
    // Flush drops presented op and the held output
    cyc(1'b1, 3'b001, 32'h40, 32'h8, 32'd1, 32'd1, 1'b1, 1'b1, 1'b1, 32'h40);
    cyc(1'b1, 3'b111, 32'h80, 32'h8, 32'd7, 32'd1, 1'b0, 1'b0, 1'b0, 32'h80);
    cyc(1'b1, 3'b111, 32'h84, 32'h8, 32'd7, 32'd1, 1'b0, 1'b1, 1'b0, 32'h80);
    idle(1'b1, 32'h84);
    // Reset while an output is held
    cyc(1'b1, 3'b000, 32'h40, 32'h8, 32'd4, 32'd4, 1'b0, 1'b0, 1'b0, 32'h40);
    do_reset();
    for (int i = 0; i < 16; i++) idle(1'b1, 32'(i * 4));

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) b = {~a[31], a[30:0]};
      pc = ($urandom_range(0, 7) == 0) ? ($urandom & 32'hFFFF_FFFC)
                                       : 32'($urandom_range(0, 255) * 4);
      cyc($urandom_range(0, 9) < 8, 3'($urandom_range(0, 7)), pc,
          $urandom & 32'hFFFF_FFFE, a, b, 1'($urandom_range(0, 1)),
          $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7,
          32'($urandom_range(0, 63) * 4));
    end

    repeat (3) idle(1'b1, 32'h0);
    check("queue_drained", 32'(q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
